// File: rtl/ftoi_pipe.sv
// Pipelined IEEE-754 binary32 to signed 32-bit integer converter with valid/ready
// handshake, four rounding modes and NV/NX flags.
module ftoi_pipe #(
  parameter int         NSTAGE     = 2,
  parameter logic [1:0] RM_DEFAULT = 2'b00
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_flags
);

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage 1 holds the raw operand and its rounding mode.
  logic        s1_valid;
  logic [31:0] s1_data;
  logic [1:0]  s1_rm;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_rm    <= RM_DEFAULT;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_rm   <= in_rm;
      end
    end
  end

  logic        sgn;
  logic [7:0]  expo;
  logic [22:0] man;
  logic [23:0] sig;
  logic [4:0]  sh;
  logic [55:0] fixed;
  logic [31:0] mag;
  logic        rnd;
  logic        stk;
  logic        inc;
  logic [32:0] mag_r;
  logic [31:0] c_data;
  logic [1:0]  c_flags;

  always_comb begin
    sgn   = s1_data[31];
    expo  = s1_data[30:23];
    man   = s1_data[22:0];
    sig   = {(expo != 8'd0), man};
    sh    = 5'(expo - 8'd126);
    fixed = '0;
    mag   = '0;
    rnd   = 1'b0;
    stk   = 1'b0;
    // Binary point sits at bit 24 of the shifted significand.
    if (expo >= 8'd126 && expo <= 8'd157) begin
      fixed = {32'd0, sig} << sh;
      mag   = fixed[55:24];
      rnd   = fixed[23];
      stk   = |fixed[22:0];
    end else if (expo < 8'd126) begin
      stk = |sig;
    end

    case (s1_rm)
      2'b00:   inc = rnd;
      2'b01:   inc = 1'b0;
      2'b10:   inc = sgn & (rnd | stk);
      default: inc = !sgn & (rnd | stk);
    endcase

    mag_r   = {1'b0, mag} + {32'd0, inc};
    c_data  = sgn ? (~mag_r[31:0] + 32'd1) : mag_r[31:0];
    c_flags = {1'b0, rnd | stk};

    if (expo == 8'hFF && man != 23'd0) begin
      c_data  = 32'h7FFF_FFFF;
      c_flags = 2'b10;
    end else if (expo >= 8'd158) begin
      // -2^31 is the only representable magnitude at or above 2^31.
      if (sgn && expo == 8'd158 && man == 23'd0) begin
        c_data  = 32'h8000_0000;
        c_flags = 2'b00;
      end else begin
        c_data  = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
        c_flags = 2'b10;
      end
    end else if (!sgn && mag_r > 33'h0_7FFF_FFFF) begin
      c_data  = 32'h7FFF_FFFF;
      c_flags = 2'b10;
    end else if (sgn && mag_r > 33'h0_8000_0000) begin
      c_data  = 32'h8000_0000;
      c_flags = 2'b10;
    end
  end

  generate
    if (NSTAGE == 1) begin : g_one
      assign out_valid = s1_valid;
      assign out_data  = c_data;
      assign out_flags = c_flags;
    end else begin : g_multi
      logic [NSTAGE-2:0] v_q;
      logic [31:0]       d_q [NSTAGE-1];
      logic [1:0]        f_q [NSTAGE-1];

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          v_q <= '0;
          for (int i = 0; i < NSTAGE - 1; i++) begin
            d_q[i] <= '0;
            f_q[i] <= '0;
          end
        end else if (en) begin
          v_q[0] <= s1_valid;
          d_q[0] <= c_data;
          f_q[0] <= c_flags;
          for (int i = 1; i < NSTAGE - 1; i++) begin
            v_q[i] <= v_q[i-1];
            d_q[i] <= d_q[i-1];
            f_q[i] <= f_q[i-1];
          end
        end
      end

      assign out_valid = v_q[NSTAGE-2];
      assign out_data  = d_q[NSTAGE-2];
      assign out_flags = f_q[NSTAGE-2];
    end
  endgenerate

endmodule

// File: tb/tb_ftoi_pipe.sv
// Scoreboard bench for ftoi_pipe: three instances (NSTAGE 2, 1, 4) share the input stream
// and are checked against a real-arithmetic reference model.
module tb_ftoi_pipe;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  f;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic [31:0] in_data;
  logic [1:0]  in_rm;
  logic        out_ready;
  logic        one = 1'b1;

  logic        ir0, ir1, ir4, ov0, ov1, ov4;
  logic [31:0] od0, od1, od4;
  logic [1:0]  of0, of1, of4;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   lat_chk = 1'b1;
  exp_t q0[$], q1[$], q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ftoi_pipe #(.NSTAGE(2), .RM_DEFAULT(2'b00)) dut2 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .in_rm(in_rm), .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_flags(of0)
  );
  ftoi_pipe #(.NSTAGE(1), .RM_DEFAULT(2'b11)) dut1 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .in_rm(in_rm), .out_valid(ov1), .out_ready(one), .out_data(od1), .out_flags(of1)
  );
  ftoi_pipe #(.NSTAGE(4), .RM_DEFAULT(2'b10)) dut4 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
    .in_rm(in_rm), .out_valid(ov4), .out_ready(one), .out_data(od4), .out_flags(of4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x, input logic [1:0] rm, input int c);
    exp_t e;
    int   ee;
    real  v, r;
    e.cyc = c;
    if (x[30:23] == 8'hFF) begin
      e.f = 2'b10;
      e.d = (x[22:0] != 0 || !x[31]) ? 32'h7FFF_FFFF : 32'h8000_0000;
      return e;
    end
    ee = (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
    v  = (real'(x[22:0]) + ((x[30:23] == 8'd0) ? 0.0 : 8388608.0)) * (2.0 ** (ee - 150));
    if (x[31]) v = -v;
    case (rm)
      2'b00:   r = (v >= 0.0) ? $floor(v + 0.5) : $ceil(v - 0.5);
      2'b01:   r = (v >= 0.0) ? $floor(v) : $ceil(v);
      2'b10:   r = $floor(v);
      default: r = $ceil(v);
    endcase
    if (r > 2147483647.0) begin
      e.d = 32'h7FFF_FFFF;
      e.f = 2'b10;
    end else if (r < -2147483648.0) begin
      e.d = 32'h8000_0000;
      e.f = 2'b10;
    end else begin
      e.d = 32'($rtoi(r));
      e.f = {1'b0, (r != v)};
    end
    return e;
  endfunction

  // Scoreboards: pop/compare before pushing the transaction accepted at the coming edge.
  exp_t e0, e1, e4;
  logic        held;
  logic [33:0] held_v;

  always @(negedge clk) begin
    if (rstn) begin
      if (held) check("n2_hold", {od0, of0}, held_v);
      if (ov0 && !out_ready) check("n2_stall_ready", ir0, 0);
      held   = ov0 && !out_ready;
      held_v = {od0, of0};
      if (ov0 && out_ready) begin
        if (q0.size() == 0) check("n2_extra", 1, 0);
        else begin
          e0 = q0.pop_front();
          check("n2_data", od0, e0.d);
          check("n2_flags", of0, e0.f);
          if (lat_chk) check("n2_lat", cyc - e0.cyc, 2);
        end
      end
      if (in_valid && ir0) q0.push_back(model(in_data, in_rm, cyc));
    end else held = 1'b0;
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (ov1) begin
        if (q1.size() == 0) check("n1_extra", 1, 0);
        else begin
          e1 = q1.pop_front();
          check("n1_data", {od1, of1}, {e1.d, e1.f});
          check("n1_lat", cyc - e1.cyc, 1);
        end
      end
      if (in_valid && ir1) q1.push_back(model(in_data, in_rm, cyc));
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (ov4) begin
        if (q4.size() == 0) check("n4_extra", 1, 0);
        else begin
          e4 = q4.pop_front();
          check("n4_data", {od4, of4}, {e4.d, e4.f});
          check("n4_lat", cyc - e4.cyc, 4);
        end
      end
      if (in_valid && ir4) q4.push_back(model(in_data, in_rm, cyc));
    end
  end

  task automatic send(input logic [31:0] d, input logic [1:0] rm);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_rm    = rm;
    @(negedge clk);
    while (!ir0 && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!ir0) check("send_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q0.size() + q1.size() + q4.size()) != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain", q0.size() + q1.size() + q4.size(), 0);
  endtask

  localparam int NV = 22;
  logic [31:0] vd [NV] = '{32'h4020_0000, 32'h4020_0000, 32'h4020_0000, 32'h4020_0000,
                           32'hC020_0000, 32'hC020_0000, 32'hC020_0000, 32'hC020_0000,
                           32'h4F00_0000, 32'hCF00_0000, 32'hCF00_0001, 32'h4EFF_FFFF,
                           32'h7FC0_0000, 32'hFFC0_0000, 32'hFF80_0000, 32'h8000_0000,
                           32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h8000_0001,
                           32'hBF00_0000, 32'h3F7F_FFFF};
  logic [1:0]  vr [NV] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3,
                           2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd1, 2'd2,
                           2'd3, 2'd0, 2'd2, 2'd2, 2'd0, 2'd1};

  task automatic run_vectors();
    for (int i = 0; i < NV; i++) send(vd[i], vr[i]);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_rm     = '0;
    out_ready = 1'b1;
    held      = 1'b0;
    #12;
    check("rst_valid", {ov0, ov1, ov4}, 0);
    check("rst_ready", {ir0, ir1, ir4}, 3'b111);
    check("rst_data", {od0, of0, od1, of1, od4, of4}, 0);
    #11 rstn = 1'b1;
    @(posedge clk);
    #1;
    run_vectors();

    // Random operands near the integer range with random backpressure.
    lat_chk = 1'b0;
    fork
      for (int i = 0; i < 40; i++)
        send({1'($urandom), 8'($urandom_range(160, 100)), 23'($urandom)}, 2'($urandom));
      repeat (50) begin
        @(posedge clk);
        #1 out_ready = 1'($urandom_range(3, 0) != 0);
      end
    join
    #1 out_ready = 1'b1;
    drain();

    // Ten back-to-back inputs with a three-cycle output stall mid-stream.
    fork
      for (int i = 0; i < 10; i++) send({1'(i % 2), 8'(128 + i), 23'(i * 123457)}, 2'(i));
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    lat_chk = 1'b1;

    // Reset with transactions in flight.
    send(32'h4040_0000, 2'd0);
    send(32'hC0A0_0000, 2'd0);
    rstn = 1'b0;
    #1;
    check("midrst_valid", {ov0, ov1, ov4}, 0);
    check("midrst_data", {od0, of0}, 0);
    check("midrst_ready", ir0, 1);
    q0.delete();
    q1.delete();
    q4.delete();
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("rst_quiet", {ov0, ov1, ov4}, 0);
    end
    @(posedge clk);
    #1;
    run_vectors();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
